// File: rtl/register_file_sb_if.sv
// register_file_sb_if: decode/writeback bus for register_file_sb
//   master drives: reg_write, write_register, reg_write_data, issue_valid, issue_register,
//                  read_register1/2, show_data
//   slave drives:  read_data1/2, ec, busy1/2, stall, busy_vec
interface register_file_sb_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    localparam int NREGS = 2 ** ADDR_W;
    logic              reg_write;
    logic [ADDR_W-1:0] write_register;
    logic [DATA_W-1:0] reg_write_data;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_register;
    logic [ADDR_W-1:0] read_register1;
    logic [ADDR_W-1:0] read_register2;
    logic [ADDR_W-1:0] show_data;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [DATA_W-1:0] ec;
    logic              busy1;
    logic              busy2;
    logic              stall;
    logic [NREGS-1:0]  busy_vec;
    modport master (
        output reg_write, write_register, reg_write_data, issue_valid, issue_register,
               read_register1, read_register2, show_data,
        input  read_data1, read_data2, ec, busy1, busy2, stall, busy_vec
    );
    modport slave (
        input  reg_write, write_register, reg_write_data, issue_valid, issue_register,
               read_register1, read_register2, show_data,
        output read_data1, read_data2, ec, busy1, busy2, stall, busy_vec
    );
endinterface

// File: rtl/register_file_sb.sv
// register_file_sb: parametrised register file with write bypass and busy scoreboard
//   i_clk  clock, all state updates on posedge
//   i_rst  synchronous active-high reset, clears registers and busy bits
//   rf     slave side of register_file_sb_if (writeback, issue, two reads, debug read)
module register_file_sb #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input logic               i_clk,
    input logic               i_rst,
    register_file_sb_if.slave rf
);
    localparam int NREGS = 2 ** ADDR_W;
    logic [DATA_W-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  r_busy;
    logic [NREGS-1:0]  w_busy_next;
    logic              w_wr_ok;
    logic              w_fwd1;
    logic              w_fwd2;
    // Dropping writes to r0 keeps it at its reset value, so reads need no extra zero mux.
    assign w_wr_ok = rf.reg_write && !(ZERO_REG && rf.write_register == '0);
    assign w_fwd1  = BYPASS && w_wr_ok && rf.write_register == rf.read_register1;
    assign w_fwd2  = BYPASS && w_wr_ok && rf.write_register == rf.read_register2;
    // An issue to the register being written back names a new producer, so set wins.
    always_comb begin
        w_busy_next = r_busy;
        for (int i = 0; i < NREGS; i++)
            w_busy_next[i] = (rf.issue_valid && rf.issue_register == ADDR_W'(i)) ? 1'b1 :
                             (rf.reg_write && rf.write_register == ADDR_W'(i)) ? 1'b0 : r_busy[i];
        if (ZERO_REG) w_busy_next[0] = 1'b0;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_busy <= '0;
        end else begin
            if (w_wr_ok) r_regs[rf.write_register] <= rf.reg_write_data;
            r_busy <= w_busy_next;
        end
    end
    assign rf.read_data1 = w_fwd1 ? rf.reg_write_data : r_regs[rf.read_register1];
    assign rf.read_data2 = w_fwd2 ? rf.reg_write_data : r_regs[rf.read_register2];
    assign rf.ec         = r_regs[rf.show_data];
    // A completing write only hides the busy bit when its data is actually forwarded.
    assign rf.busy1      = r_busy[rf.read_register1] && !w_fwd1;
    assign rf.busy2      = r_busy[rf.read_register2] && !w_fwd2;
    assign rf.stall      = rf.busy1 || rf.busy2;
    assign rf.busy_vec   = r_busy;
endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: directed bench with a behavioural model for three configurations
module tb_register_file_sb;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    // 0: 8x4 bypass, 1: 8x4 no bypass (same stimulus as 0), 2: 16x8 zero-reg bypass
    localparam bit ZR [3] = '{1'b0, 1'b0, 1'b1};
    localparam bit BP [3] = '{1'b1, 1'b0, 1'b1};
    int m  [3][8];
    bit bz [3][8];
    register_file_sb_if #(.DATA_W(8),  .ADDR_W(2)) ia ();
    register_file_sb_if #(.DATA_W(8),  .ADDR_W(2)) ib ();
    register_file_sb_if #(.DATA_W(16), .ADDR_W(3)) ic ();
    assign ib.reg_write      = ia.reg_write;
    assign ib.write_register = ia.write_register;
    assign ib.reg_write_data = ia.reg_write_data;
    assign ib.issue_valid    = ia.issue_valid;
    assign ib.issue_register = ia.issue_register;
    assign ib.read_register1 = ia.read_register1;
    assign ib.read_register2 = ia.read_register2;
    assign ib.show_data      = ia.show_data;
    register_file_sb #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1'b0), .BYPASS(1'b1)) u_a (
        .i_clk(clk), .i_rst(rst), .rf(ia));
    register_file_sb #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_b (
        .i_clk(clk), .i_rst(rst), .rf(ib));
    register_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_c (
        .i_clk(clk), .i_rst(rst), .rf(ic));
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task upd(input int k, input bit we, input int wa, input int wd, input bit iv, input int ir);
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m[k][i]  <= 0;
                bz[k][i] <= 1'b0;
            end
        end else begin
            if (we && !(ZR[k] && wa == 0)) m[k][wa] <= wd;
            if (iv && !(ZR[k] && ir == 0)) bz[k][ir] <= 1'b1;
            if (we && !(iv && ir == wa)) bz[k][wa] <= 1'b0;
        end
    endtask
    always @(posedge clk) begin
        upd(0, ia.reg_write, int'(ia.write_register), int'(ia.reg_write_data), ia.issue_valid, int'(ia.issue_register));
        upd(1, ib.reg_write, int'(ib.write_register), int'(ib.reg_write_data), ib.issue_valid, int'(ib.issue_register));
        upd(2, ic.reg_write, int'(ic.write_register), int'(ic.reg_write_data), ic.issue_valid, int'(ic.issue_register));
    end
    task automatic cmp(input string t, input int k, input bit we, input int wa, input int wd,
                       input int r1, input int r2, input int sd, input int rd1, input int rd2,
                       input int ec, input bit b1, input bit b2, input bit st, input int bv);
        bit f1 = BP[k] && we && wa == r1 && !(ZR[k] && wa == 0);
        bit f2 = BP[k] && we && wa == r2 && !(ZR[k] && wa == 0);
        bit x1 = bz[k][r1] && !f1;
        bit x2 = bz[k][r2] && !f2;
        int ev = 0;
        for (int i = 0; i < 8; i++) ev |= int'(bz[k][i]) << i;
        chk({t, ".rd1"}, rd1, f1 ? wd : m[k][r1]);
        chk({t, ".rd2"}, rd2, f2 ? wd : m[k][r2]);
        chk({t, ".ec"}, ec, m[k][sd]);
        chk({t, ".busy1"}, int'(b1), int'(x1));
        chk({t, ".busy2"}, int'(b2), int'(x2));
        chk({t, ".stall"}, int'(st), int'(x1 | x2));
        chk({t, ".busy_vec"}, bv, ev);
    endtask
    task tick;
        #2;
        if (!rst) begin
            cmp("A", 0, ia.reg_write, int'(ia.write_register), int'(ia.reg_write_data),
                int'(ia.read_register1), int'(ia.read_register2), int'(ia.show_data),
                int'(ia.read_data1), int'(ia.read_data2), int'(ia.ec), ia.busy1, ia.busy2, ia.stall, int'(ia.busy_vec));
            cmp("B", 1, ib.reg_write, int'(ib.write_register), int'(ib.reg_write_data),
                int'(ib.read_register1), int'(ib.read_register2), int'(ib.show_data),
                int'(ib.read_data1), int'(ib.read_data2), int'(ib.ec), ib.busy1, ib.busy2, ib.stall, int'(ib.busy_vec));
            cmp("C", 2, ic.reg_write, int'(ic.write_register), int'(ic.reg_write_data),
                int'(ic.read_register1), int'(ic.read_register2), int'(ic.show_data),
                int'(ic.read_data1), int'(ic.read_data2), int'(ic.ec), ic.busy1, ic.busy2, ic.stall, int'(ic.busy_vec));
        end
        @(posedge clk);
        #1;
    endtask
    task set_ab(input bit we, input int wa, input int wd, input bit iv, input int ir,
                input int r1, input int r2, input int sd);
        ia.reg_write      = we;
        ia.write_register = 2'(wa);
        ia.reg_write_data = 8'(wd);
        ia.issue_valid    = iv;
        ia.issue_register = 2'(ir);
        ia.read_register1 = 2'(r1);
        ia.read_register2 = 2'(r2);
        ia.show_data      = 2'(sd);
    endtask
    task set_c(input bit we, input int wa, input int wd, input bit iv, input int ir,
               input int r1, input int r2, input int sd);
        ic.reg_write      = we;
        ic.write_register = 3'(wa);
        ic.reg_write_data = 16'(wd);
        ic.issue_valid    = iv;
        ic.issue_register = 3'(ir);
        ic.read_register1 = 3'(r1);
        ic.read_register2 = 3'(r2);
        ic.show_data      = 3'(sd);
    endtask
    initial begin
        rst = 1'b1;
        set_ab(1, 1, 'h5A, 1, 1, 1, 1, 1);
        set_c(1, 1, 'h1234, 1, 1, 1, 1, 1);
        tick;
        rst = 1'b0;
        set_ab(0, 0, 0, 0, 0, 1, 2, 1);
        set_c(0, 0, 0, 0, 0, 1, 2, 1);
        #1;
        chk("reset.A.rd1", int'(ia.read_data1), 'h00);
        chk("reset.A.ec", int'(ia.ec), 'h00);
        chk("reset.A.busy_vec", int'(ia.busy_vec), 0);
        chk("reset.B.stall", int'(ib.stall), 0);
        chk("reset.C.busy_vec", int'(ic.busy_vec), 0);
        tick;
        set_ab(1, 2, 'hA5, 0, 0, 0, 0, 0);
        tick;
        set_ab(0, 0, 0, 0, 0, 2, 0, 2);
        #1;
        chk("wr.A.rd1", int'(ia.read_data1), 'hA5);
        chk("wr.A.ec", int'(ia.ec), 'hA5);
        chk("wr.B.rd1", int'(ib.read_data1), 'hA5);
        chk("wr.A.busy_vec", int'(ia.busy_vec), 0);
        tick;
        set_ab(1, 3, 'h11, 0, 0, 0, 0, 0);
        tick;
        set_ab(1, 3, 'h77, 0, 0, 0, 3, 3);
        #1;
        chk("byp.A.rd2", int'(ia.read_data2), 'h77);
        chk("byp.A.ec", int'(ia.ec), 'h11);
        chk("byp.B.rd2", int'(ib.read_data2), 'h11);
        tick;
        set_ab(0, 0, 0, 0, 0, 0, 3, 3);
        #1;
        chk("byp.B.rd2_next", int'(ib.read_data2), 'h77);
        tick;
        set_ab(0, 0, 0, 1, 1, 0, 0, 0);
        tick;
        set_ab(0, 0, 0, 0, 0, 1, 1, 0);
        #1;
        chk("sb.A.busy1", int'(ia.busy1), 1);
        chk("sb.A.busy2", int'(ia.busy2), 1);
        chk("sb.A.stall", int'(ia.stall), 1);
        chk("sb.B.busy1", int'(ib.busy1), 1);
        tick;
        set_ab(1, 1, 'h3C, 0, 0, 1, 0, 0);
        #1;
        chk("sbwb.A.busy1", int'(ia.busy1), 0);
        chk("sbwb.A.rd1", int'(ia.read_data1), 'h3C);
        chk("sbwb.A.stall", int'(ia.stall), 0);
        chk("sbwb.B.busy1", int'(ib.busy1), 1);
        chk("sbwb.B.rd1", int'(ib.read_data1), 'h00);
        tick;
        set_ab(0, 0, 0, 0, 0, 1, 0, 0);
        #1;
        chk("sbwb.B.busy1_next", int'(ib.busy1), 0);
        chk("sbwb.B.rd1_next", int'(ib.read_data1), 'h3C);
        tick;
        set_ab(0, 0, 0, 1, 2, 0, 0, 0);
        tick;
        set_ab(1, 2, 'hC3, 1, 2, 0, 0, 0);
        tick;
        set_ab(0, 0, 0, 0, 0, 2, 2, 2);
        #1;
        chk("coll.A.busy_vec", int'(ia.busy_vec), 'h4);
        chk("coll.A.rd1", int'(ia.read_data1), 'hC3);
        chk("coll.A.busy2", int'(ia.busy2), 1);
        tick;
        set_ab(1, 2, 'h05, 0, 0, 0, 0, 0);
        tick;
        set_ab(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("clr.A.busy_vec", int'(ia.busy_vec), 0);
        tick;
        set_c(1, 0, 'hFF, 1, 0, 0, 0, 0);
        #1;
        chk("zr.C.rd1_same", int'(ic.read_data1), 0);
        chk("zr.C.busy1_same", int'(ic.busy1), 0);
        tick;
        set_c(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("zr.C.rd1", int'(ic.read_data1), 0);
        chk("zr.C.ec", int'(ic.ec), 0);
        chk("zr.C.busy_vec", int'(ic.busy_vec), 0);
        tick;
        set_c(1, 7, 'hBEEF, 0, 0, 0, 7, 7);
        #1;
        chk("w16.C.rd2_byp", int'(ic.read_data2), 'hBEEF);
        chk("w16.C.ec_old", int'(ic.ec), 0);
        tick;
        set_c(0, 0, 0, 1, 7, 7, 7, 7);
        #1;
        chk("w16.C.rd1", int'(ic.read_data1), 'hBEEF);
        chk("w16.C.ec", int'(ic.ec), 'hBEEF);
        tick;
        set_c(0, 0, 0, 0, 0, 7, 0, 0);
        #1;
        chk("w16.C.busy_vec", int'(ic.busy_vec), 'h80);
        chk("w16.C.busy1", int'(ic.busy1), 1);
        tick;
        rst = 1'b1;
        set_ab(1, 3, 'h99, 1, 3, 3, 3, 3);
        set_c(0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        rst = 1'b0;
        set_ab(0, 0, 0, 0, 0, 3, 1, 2);
        set_c(0, 0, 0, 0, 0, 7, 7, 7);
        #1;
        chk("rst2.A.rd1", int'(ia.read_data1), 0);
        chk("rst2.A.busy_vec", int'(ia.busy_vec), 0);
        chk("rst2.C.ec", int'(ic.ec), 0);
        chk("rst2.C.busy_vec", int'(ic.busy_vec), 0);
        tick;
        tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
